// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: FSM states and ALU function codes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef logic [1:0] func_t;

  localparam func_t FUNC_ADD = 2'd0;
  localparam func_t FUNC_SUB = 2'd1;
  localparam func_t FUNC_AND = 2'd2;
  localparam func_t FUNC_OR  = 2'd3;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU shared between requesters; results wrap to WIDTH.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  func_t            func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (func)
      FUNC_ADD: result = a + b;
      FUNC_SUB: result = a - b;
      FUNC_AND: result = a & b;
      default:  result = a | b;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid index at or after prio_ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] prio_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_valid
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any_valid = |valid;
    j         = 0;
    // Walk offsets from farthest to nearest so the nearest valid index wins.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(prio_ptr) + i;
      if (j >= N) j = j - N;
      if (valid[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between N_REQ valid/ready requesters,
// returning each registered result with its requester id on one response port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][1:0]       req_func,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic [WIDTH-1:0]            resp_result
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   prio_ptr_reg;
  logic [ID_W-1:0]   cur_id_reg;
  func_t             op_func_reg;
  logic [WIDTH-1:0]  op_a_reg, op_b_reg;
  logic              resp_valid_reg;
  logic [ID_W-1:0]   resp_id_reg;
  logic [WIDTH-1:0]  resp_result_reg;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_valid;
  logic              take;
  logic [WIDTH-1:0]  alu_result;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
    .valid     (req_valid),
    .prio_ptr  (prio_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .func   (op_func_reg),
    .a      (op_a_reg),
    .b      (op_b_reg),
    .result (alu_result)
  );

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    case (state_reg)
      IDLE: take = any_valid;
      EXEC: state_next = RESP;
      RESP: begin
        if (resp_ready) begin
          take       = any_valid;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Grant is combinational, so it must also be masked while reset is held.
    if (reset) take = 1'b0;
    if (take) state_next = EXEC;
  end

  assign req_ready = take ? grant : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      prio_ptr_reg    <= '0;
      cur_id_reg      <= '0;
      op_func_reg     <= FUNC_ADD;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= '0;
      resp_result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        op_func_reg <= req_func[grant_idx];
        op_a_reg    <= req_a[grant_idx];
        op_b_reg    <= req_b[grant_idx];
        cur_id_reg  <= grant_idx;
      end
      if (state_reg == EXEC) begin
        resp_result_reg <= alu_result;
        resp_id_reg     <= cur_id_reg;
        resp_valid_reg  <= 1'b1;
        prio_ptr_reg    <= (cur_id_reg == ID_W'(N_REQ - 1)) ? '0 : cur_id_reg + ID_W'(1);
      end else if (state_reg == RESP && resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign resp_valid  = resp_valid_reg;
  assign resp_id     = resp_id_reg;
  assign resp_result = resp_result_reg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin sequencer that shares the single combinational `alu` (2-bit `func`, `WIDTH`-bit `a`/`b`, `result`) between `N_REQ` requesters. Each requester uses a valid/ready handshake. The block grants one request at a time and latches its operands into the ALU. It returns the registered result with the requester id on a single valid/ready response port. It sits between the issuing units and the shared `alu` instance, which it owns.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 32: operand/result width; must match `alu`.
- `ID_W`, default `$clog2(N_REQ)`: width of `resp_id`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  N_REQ  request valid, one bit per requester.
- `req_ready`  out  N_REQ  one-hot grant; handshake completes when valid&ready.
- `req_func`  in  N_REQ×2  ALU function code per requester.
- `req_a`, `req_b`  in  N_REQ×WIDTH  operands per requester.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  ID_W  index of the requester that issued the result.
- `resp_result`  out  WIDTH  registered `alu.result`.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` is set, `rr_arbiter` picks the first valid index at or after `prio_ptr` (wrapping N_REQ-1→0).
  - `req_ready[g]` is asserted combinationally for the winner `g` only.
  - func/a/b are latched into `op_*` registers, `cur_id<=g`, then → EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC:**
  - `alu` inputs are driven from the `op_*` registers.
  - `resp_result<=alu.result`, `resp_id<=cur_id`, `resp_valid<=1`, then → RESP.
  - `prio_ptr<=(cur_id+1) mod N_REQ`.
- **RESP:**
  - `resp_valid` stays high and `resp_id`/`resp_result` are held stable until `resp_ready`.
  - On `resp_ready`, `resp_valid` drops next cycle.
  - Same cycle as `resp_ready`: if any `req_valid` is set, grant it as in IDLE and go → EXEC (back-to-back). Otherwise → IDLE.
  - Without `resp_ready`, all `req_ready` stay 0.
- Every request gets a response; results are never dropped or reordered.
- `func` is opaque to this block. Code 0 is add.
- Results are truncated to WIDTH, as produced by `alu`.
- Requesters hold `req_valid` and operands stable until granted. `req_ready` may depend on `req_valid`; `req_valid` must not depend on `req_ready`.
- `req_ready` never asserts in EXEC, and never asserts when `req_valid` is 0.

## Timing
- Reset values:
  - state=IDLE, `prio_ptr`=0, `cur_id`=0, `op_*`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_result`=0, `req_ready`=0.
- Latency:
  - Grant in cycle T gives `resp_valid` high in cycle T+2.
  - Throughput is one op per 2 cycles with `resp_ready` held high; one op per 3 cycles when entering from IDLE.
- Reset asserted mid-operation clears everything immediately. An in-flight result is lost, and no `req_ready` or `resp_valid` is asserted while `reset` is high.
- `prio_ptr` wraps from N_REQ-1 to 0.
- A sole requester is always granted, regardless of `prio_ptr`.

## Structure
- Package `alu_arbiter_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t`
  - `typedef logic [1:0] func_t`
  - `localparam func_t FUNC_ADD = 2'd0`
- Sub-module `rr_arbiter` (N parameter): inputs are the valid mask and `prio_ptr`; outputs are the one-hot grant, the grant index and `any_valid`. It is purely combinational.
- `alu` is instantiated once inside `alu_arbiter`.

## Test plan
- **Single request:** after reset, req 2 with a=2, b=3, func=0 at cycle 0 → `req_ready`=4'b0100 in cycle 0; `resp_valid`=1, `resp_id`=2, `resp_result`=5 in cycle 2.
- **Fairness:** all four requests valid from reset with `resp_ready`=1, func=0, a=id, b=10 → grants in order 0,1,2,3 every 2 cycles; results 10, 11, 12, 13 with matching ids.
- **Wrap:** last grant was id 3, then requests 0 and 3 valid → 0 granted first, 3 next.
- **Backpressure:** `resp_ready`=0 for 5 cycles with req 1 pending → `resp_valid`, `resp_id`, `resp_result` held stable; `req_ready`=0 throughout. Release → req 1 granted in the same cycle.
- **Reset mid-EXEC:** assert `reset` during EXEC → all outputs 0 immediately; after release, the still-valid request is re-granted from IDLE with `prio_ptr`=0.
- **Overflow:** a=32'hFFFF_FFFF, b=1, func=0 → `resp_result`=0.
